// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU front end.
// Provides the fetch FSM state type, instruction width and PC increment.
package cpu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} ifetch_state_t;
   localparam int INST_W = 32;
   localparam int PC_INC = 4;
endpackage

// File: rtl/ifetch_perf.sv
// ifetch_perf: fetch performance counters, all wrapping at 2^32.
// Ports: clk, reset_n (sync, active-low); fetch/stall/flush event strobes;
//        fetch_cnt/stall_cnt/flush_cnt running totals.
module ifetch_perf (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         fetch_cnt <= fetch_cnt + 32'(fetch);
         stall_cnt <= stall_cnt + 32'(stall);
         flush_cnt <= flush_cnt + 32'(flush);
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: program counter, instruction-memory read requests and decode handoff.
// Ports: clk, reset_n (sync, active-low);
//        imem_req/imem_addr/imem_ack/imem_rdata instruction-memory read port;
//        inst/inst_pc/inst_valid/inst_ready decode handshake;
//        br_taken/br_target redirect from branch resolution;
//        fetch_cnt/stall_cnt/flush_cnt perf counters, live only when
//        IFETCH_PERF_CNT_EN is defined, otherwise tied to 0.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);
   ifetch_state_t     state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, addr_nx, inst_pc_nx, tgt;
   logic [INST_W-1:0] inst_nx;
   logic              valid_nx;

   assign tgt      = br_target & ~ADDR_W'(2'b11);
   assign imem_req = (state == REQ) || (state == DROP);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         imem_addr  <= RESET_PC;
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         imem_addr  <= addr_nx;
         inst       <= inst_nx;
         inst_pc    <= inst_pc_nx;
         inst_valid <= valid_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      inst_nx    = inst;
      inst_pc_nx = inst_pc;
      valid_nx   = inst_valid;
      case (state)
         IDLE: state_nx = REQ;
         REQ: begin
            // A redirect kills this fetch; if its ack already arrived the
            // memory is free, otherwise wait out the exposed request in DROP.
            if (br_taken)
               state_nx = imem_ack ? REQ : DROP;
            else if (imem_ack) begin
               state_nx   = HOLD;
               inst_nx    = imem_rdata;
               inst_pc_nx = pc;
               valid_nx   = 1'b1;
               pc_nx      = pc + ADDR_W'(PC_INC);
            end
         end
         HOLD: begin
            if (br_taken || inst_ready) begin
               state_nx = REQ;
               valid_nx = 1'b0;
            end
         end
         DROP: if (imem_ack) state_nx = REQ;
      endcase
      if (br_taken) pc_nx = tgt;
      // The address register only tracks pc when a fresh request starts, so
      // DROP keeps presenting the abandoned address until its ack.
      addr_nx = (state_nx == REQ) ? pc_nx : imem_addr;
   end

`ifdef IFETCH_PERF_CNT_EN
   ifetch_perf u_perf (
      .clk       (clk),
      .reset_n   (reset_n),
      .fetch     (inst_valid & inst_ready & ~br_taken),
      .stall     (inst_valid & ~inst_ready),
      .flush     (br_taken),
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );
`else
   assign fetch_cnt = '0;
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a latency-programmable memory model.
module tb_inst_fetch;
   localparam int AW = 64;
`ifdef IFETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   typedef struct { logic [AW-1:0] pc; logic [31:0] data; } exp_t;

   logic          clk = 1'b0, reset_n = 1'b0, imem_ack = 1'b0, inst_ready = 1'b0, br_taken = 1'b0;
   logic [AW-1:0] br_target = '0, imem_addr, inst_pc, mem_a = '0;
   logic [31:0]   imem_rdata = '0, inst, fetch_cnt, stall_cnt, flush_cnt;
   logic          imem_req, inst_valid;
   int            checks = 0, failures = 0, mem_lat = 1, mem_cnt = 0;
   bit            mem_en = 1'b0, busy = 1'b0, ok;
   exp_t          sb[$];

   inst_fetch #(.ADDR_W(AW), .RESET_PC('0)) dut (
      .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .br_taken(br_taken),
      .br_target(br_target), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [AW-1:0] a);
      return 32'h91000421 ^ a[31:0];
   endfunction

   task automatic expect_at(input logic [AW-1:0] a);
      sb.push_back('{a, word(a)});
   endtask

   // One clock: score the handshake of the ending cycle, advance, then run the memory model.
   task automatic step;
      exp_t e;
      if (reset_n && inst_valid && inst_ready && !br_taken) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got pc=%h inst=%h, none expected", inst_pc, inst);
         end else begin
            e = sb.pop_front();
            if ({inst_pc, inst} !== {e.pc, e.data}) begin
               failures++;
               $display("FAIL sb_inst got pc=%h inst=%h exp pc=%h inst=%h", inst_pc, inst, e.pc, e.data);
            end
         end
      end
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (!reset_n || !mem_en) busy = 1'b0;
      else if (busy) begin
         checks++;
         if (!imem_req || imem_addr !== mem_a) begin
            failures++;
            $display("FAIL mem_addr_stable got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, mem_a);
         end
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = word(mem_a);
            busy       = 1'b0;
         end
      end else if (imem_req) begin
         busy    = 1'b1;
         mem_cnt = mem_lat;
         mem_a   = imem_addr;
      end
   endtask

   task automatic drain(input int max, output bit done);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         step;
         n++;
      end
      done = (sb.size() == 0);
   endtask

   task automatic do_reset;
      reset_n = 1'b0; inst_ready = 1'b0; br_taken = 1'b0; br_target = '0; mem_en = 1'b0;
      sb.delete();
      step;
      step;
      mem_en = 1'b1;
   endtask

   task automatic test_fetch;
      do_reset; mem_lat = 1; expect_at(0); reset_n = 1'b1;
      step; checks++;
      if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin failures++; $display("FAIL first_req got %b/%h exp 1/0", imem_req, imem_addr); end
      step; checks++;
      if (inst_valid !== 1'b0) begin failures++; $display("FAIL early_valid got %b exp 0", inst_valid); end
      step; checks++;
      if ({inst_valid, imem_req, inst, inst_pc} !== {1'b1, 1'b0, 32'h91000421, 64'h0}) begin
         failures++; $display("FAIL first_inst got v=%b req=%b inst=%h pc=%h exp 1 0 91000421 0", inst_valid, imem_req, inst, inst_pc);
      end
      inst_ready = 1'b1; expect_at(4); expect_at(8);
      step; checks++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, 64'h4, 1'b0}) begin failures++; $display("FAIL second_req got %b/%h/%b exp 1/4/0", imem_req, imem_addr, inst_valid); end
      drain(30, ok); checks++;
      if (!ok) begin failures++; $display("FAIL fetch_drain got %0d left exp 0", sb.size()); end
      checks++;
      if (fetch_cnt !== (PERF ? 32'd3 : 32'd0)) begin failures++; $display("FAIL fetch_cnt got %0d exp %0d", fetch_cnt, PERF ? 3 : 0); end
   endtask

   task automatic test_reset;
      do_reset; checks++;
      if ({imem_req, imem_addr, inst, inst_pc, inst_valid} !== {1'b0, 64'h0, 32'h0, 64'h0, 1'b0}) begin
         failures++; $display("FAIL reset_outputs got req=%b addr=%h inst=%h pc=%h v=%b exp all 0", imem_req, imem_addr, inst, inst_pc, inst_valid);
      end
      checks++;
      if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin failures++; $display("FAIL reset_cnt got %0d %0d %0d exp 0 0 0", fetch_cnt, stall_cnt, flush_cnt); end
   endtask

   task automatic test_stall;
      do_reset; mem_lat = 1; expect_at(0); reset_n = 1'b1;
      repeat (3) step;
      checks++;
      if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got %b exp 1", inst_valid); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({inst_valid, imem_req, inst, inst_pc} !== {1'b1, 1'b0, word(0), 64'h0}) begin
            failures++; $display("FAIL stall_hold got v=%b req=%b inst=%h pc=%h exp 1 0 %h 0", inst_valid, imem_req, inst, inst_pc, word(0));
         end
         step;
      end
      checks++;
      if (stall_cnt !== (PERF ? 32'd5 : 32'd0)) begin failures++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, PERF ? 5 : 0); end
      inst_ready = 1'b1;
      step; checks++;
      if ({inst_valid, stall_cnt, fetch_cnt} !== {1'b0, PERF ? 32'd5 : 32'd0, PERF ? 32'd1 : 32'd0}) begin
         failures++; $display("FAIL stall_release got v=%b stall=%0d fetch=%0d", inst_valid, stall_cnt, fetch_cnt);
      end
   endtask

   task automatic test_flush_hold;
      do_reset; mem_lat = 1; reset_n = 1'b1;
      repeat (3) step;
      br_taken = 1'b1; br_target = 64'h103; inst_ready = 1'b1;
      step; br_taken = 1'b0; checks++;
      if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h100}) begin
         failures++; $display("FAIL flush_hold got v=%b req=%b addr=%h exp 0 1 100", inst_valid, imem_req, imem_addr);
      end
      checks++;
      if (flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin failures++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, PERF ? 1 : 0); end
      expect_at(64'h100);
      drain(20, ok); checks++;
      if (!ok) begin failures++; $display("FAIL flush_drain got %0d left exp 0", sb.size()); end
   endtask

   task automatic test_drop(input bit retarget);
      logic [AW-1:0] want;
      want = retarget ? 64'h80 : 64'h40;
      do_reset; mem_lat = 3; inst_ready = 1'b1; reset_n = 1'b1;
      step; checks++;
      if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin failures++; $display("FAIL drop_req got %b/%h exp 1/0", imem_req, imem_addr); end
      br_taken = 1'b1; br_target = 64'h40;
      for (int i = 0; i < 3; i++) begin
         step;
         if (i == 0 && retarget) br_target = 64'h80;
         else br_taken = 1'b0;
         checks++;
         if ({imem_req, imem_addr, inst_valid} !== {1'b1, 64'h0, 1'b0}) begin
            failures++; $display("FAIL drop_hold got req=%b addr=%h v=%b exp 1 0 0", imem_req, imem_addr, inst_valid);
         end
      end
      step; checks++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, want, 1'b0}) begin
         failures++; $display("FAIL drop_target got req=%b addr=%h v=%b exp 1 %h 0", imem_req, imem_addr, inst_valid, want);
      end
      expect_at(want);
      drain(30, ok); checks++;
      if (!ok) begin failures++; $display("FAIL drop_drain got %0d left exp 0", sb.size()); end
      checks++;
      if (flush_cnt !== (PERF ? (retarget ? 32'd2 : 32'd1) : 32'd0)) begin failures++; $display("FAIL drop_flush_cnt got %0d", flush_cnt); end
   endtask

   task automatic test_req_ack_redirect;
      do_reset; mem_lat = 1; inst_ready = 1'b1; reset_n = 1'b1;
      step;
      step;
      br_taken = 1'b1; br_target = 64'h202;
      step; br_taken = 1'b0; checks++;
      if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h200}) begin
         failures++; $display("FAIL req_ack_redirect got v=%b req=%b addr=%h exp 0 1 200", inst_valid, imem_req, imem_addr);
      end
      expect_at(64'h200);
      drain(20, ok); checks++;
      if (!ok) begin failures++; $display("FAIL req_ack_drain got %0d left exp 0", sb.size()); end
   endtask

   task automatic test_wrap;
      do_reset; mem_lat = 1; inst_ready = 1'b1; br_taken = 1'b1; br_target = '1; reset_n = 1'b1;
      expect_at(64'hFFFF_FFFF_FFFF_FFFC);
      step; br_taken = 1'b0; checks++;
      if ({imem_req, imem_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin failures++; $display("FAIL wrap_first got %b/%h exp 1/fffffffffffffffc", imem_req, imem_addr); end
      expect_at(64'h0);
      repeat (3) step;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin failures++; $display("FAIL wrap_next got %b/%h exp 1/0", imem_req, imem_addr); end
      drain(20, ok); checks++;
      if (!ok) begin failures++; $display("FAIL wrap_drain got %0d left exp 0", sb.size()); end
   endtask

   task automatic test_reset_mid;
      do_reset; mem_lat = 3; inst_ready = 1'b1; expect_at(0); reset_n = 1'b1;
      drain(20, ok); checks++;
      if (!ok || {imem_req, imem_addr} !== {1'b1, 64'h4}) begin failures++; $display("FAIL mid_pre got left=%0d req=%b addr=%h exp 0 1 4", sb.size(), imem_req, imem_addr); end
      reset_n = 1'b0; mem_en = 1'b0;
      step; checks++;
      if ({imem_req, imem_addr, inst, inst_pc, inst_valid} !== {1'b0, 64'h0, 32'h0, 64'h0, 1'b0}) begin
         failures++; $display("FAIL mid_reset got req=%b addr=%h inst=%h pc=%h v=%b exp all 0", imem_req, imem_addr, inst, inst_pc, inst_valid);
      end
      step;
      reset_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         step; checks++;
         if ({imem_req, imem_addr, inst_valid} !== {1'b1, 64'h0, 1'b0}) begin
            failures++; $display("FAIL stray_ack got req=%b addr=%h v=%b exp 1 0 0", imem_req, imem_addr, inst_valid);
         end
      end
      mem_en = 1'b1; expect_at(0);
      drain(20, ok); checks++;
      if (!ok) begin failures++; $display("FAIL mid_drain got %0d left exp 0", sb.size()); end
   endtask

   initial begin
      test_fetch;
      test_reset;
      test_stall;
      test_flush_hold;
      test_drop(1'b0);
      test_drop(1'b1);
      test_req_ack_redirect;
      test_wrap;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the single-cycle/multi-cycle CPU: owns the program counter, issues word reads to instruction memory, and presents each fetched 32-bit instruction to the decode stage, whose control decoder consumes bits [31:21]. It is the producer side of the instruction stream. Branch resolution downstream feeds back a taken/target redirect that flushes in-flight fetches.

## Interface
- ADDR_W, 64: PC and instruction-memory address width.
- RESET_PC, 0: PC loaded on reset; must be 4-byte aligned.
- clk  in  1  sole clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_req  out  1  read request; held until imem_ack.
- imem_addr  out  ADDR_W  word address of request; stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  instruction to decode.
- inst_pc  out  ADDR_W  address of inst.
- inst_valid  out  1  inst/inst_pc valid.
- inst_ready  in  1  decode accepts; transfer when inst_valid & inst_ready.
- br_taken  in  1  redirect pulse from branch resolution (B, CBZ, B.LT).
- br_target  in  ADDR_W  redirect address; bits [1:0] ignored, forced 0.
- fetch_cnt, stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
- States: IDLE, REQ, HOLD, DROP.
- IDLE: entered only from reset; next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 -> HOLD.
- HOLD: inst_valid=1, imem_req=0, inst/inst_pc stable. On inst_valid & inst_ready: inst_valid<=0 -> REQ.
- DROP: imem_req=1 held with the original address (request already exposed); on imem_ack data discarded -> REQ.
- Redirect (br_taken=1) has highest priority, in every state pc<={br_target[ADDR_W-1:2],2'b00}:
  - IDLE or HOLD -> REQ; HOLD clears inst_valid (instruction flushed, even if inst_ready=1 same cycle).
  - REQ without imem_ack -> DROP. REQ with imem_ack same cycle -> data discarded -> REQ.
  - DROP without ack: stay DROP, latest target wins. DROP with ack -> REQ.
- pc+4 wraps modulo 2^ADDR_W; no error.
- Reset mid-fetch: outstanding request abandoned; memory must tolerate req dropping; a later stray ack in IDLE is ignored.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0, state IDLE, counters 0.
- imem_req first high 1 cycle after reset_n rises.
- imem_ack earliest 1 cycle after imem_req rises; ack in same cycle as req-rise is illegal.
- inst_valid rises the cycle after imem_ack; peak throughput 1 instruction per 3 cycles (REQ, ack, HOLD) with 1-cycle memory.
- Redirect: imem_req with new address appears the cycle after br_taken (IDLE/HOLD) or the cycle after the dropped ack (REQ/DROP).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- IFETCH_PERF_CNT_EN defined: fetch_cnt +1 per inst handshake, stall_cnt +1 per cycle with inst_valid & !inst_ready, flush_cnt +1 per br_taken cycle; all wrap at 2^32, cleared by reset.
- Undefined: counters not instantiated, the three ports driven constant 0.

## Structure
- Shared package cpu_pkg: ifetch_state_t enum (IDLE, REQ, HOLD, DROP), INST_W=32, PC_INC=4.
- Sub-module ifetch_perf (three counters) instantiated only under IFETCH_PERF_CNT_EN.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory returning 0x91000421 (ADDI) -> imem_req at cycle 1 addr 0; inst_valid at cycle 3, inst=0x91000421, inst_pc=0; next req addr 4.
- inst_ready low 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0, stall_cnt=5 (macro on), 0 (macro off).
- br_taken target 0x103 while in HOLD -> inst_valid drops next cycle, next imem_addr=0x100, flush_cnt=1.
- br_taken target 0x40 in REQ with 3-cycle memory latency -> DROP; returned word discarded (no inst_valid); next request addr 0x40.
- Second br_taken target 0x80 while in DROP -> after ack, request addr 0x80, not 0x40.
- pc=2^ADDR_W-4 fetch -> next imem_addr=0; reset_n low during REQ -> all outputs at reset values next cycle, stray ack ignored.
